// File: rtl/v_pkg.sv
// Shared types and default sizing for the vector lane sequencer.
//   state_e     : sequencer FSM states
//   addr_t      : element address within one vector register
//   lane_addr_t : one lane's {valid, addr} as issued on the read port
//                 and carried down the write-back delay line
//   clamp_vl    : limits a requested vector length to the register size
package v_pkg;

    localparam int v_vlen_lp       = 8;
    localparam int v_vdw_lp        = 32;
    localparam int v_lanes_lp      = 4;
    localparam int v_exe_lat_lp    = 2;
    localparam int v_addr_width_lp = $clog2(v_vlen_lp);
    localparam int v_vl_width_lp   = $clog2(v_vlen_lp + 1);
    localparam int v_beats_lp      = v_vlen_lp / v_lanes_lp;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic [v_addr_width_lp-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } lane_addr_t;

    function automatic int clamp_vl(int vl, int vmax);
        return (vl > vmax) ? vmax : vl;
    endfunction

endpackage

// File: rtl/v_wb_delay.sv
// Write-back delay line: exe_lat_p stages of per-lane {valid, addr},
// advancing only when en_i is high so a stall freezes every entry.
//   clk_i, reset_n_i : clock, async active-low reset (clears all stages)
//   en_i             : shift enable (low while stalled)
//   in_i             : per-lane read issue entering the line
//   out_o            : oldest stage, i.e. the write presented this cycle
//   any_valid_o      : a valid entry will still be in the line after the
//                      next shift (incoming entry or any non-final stage)
module v_wb_delay
    import v_pkg::*;
#(
    parameter int lanes_p   = v_lanes_lp,
    parameter int exe_lat_p = v_exe_lat_lp
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    input  lane_addr_t [lanes_p-1:0] in_i,
    output lane_addr_t [lanes_p-1:0] out_o,
    output logic                     any_valid_o
);

    lane_addr_t [exe_lat_p-1:0][lanes_p-1:0] line_q;
    lane_addr_t [exe_lat_p-1:0][lanes_p-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (en_i) begin
            line_d[0] = in_i;
            for (int s = 1; s < exe_lat_p; s++) begin
                line_d[s] = line_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign out_o = line_q[exe_lat_p-1];

    // The final stage is excluded: it retires in the cycle it is presented,
    // so once only it remains the sequencer can leave DRAIN on that edge.
    always_comb begin
        any_valid_o = 1'b0;
        for (int l = 0; l < lanes_p; l++) begin
            any_valid_o = any_valid_o | in_i[l].valid;
        end
        for (int s = 0; s < exe_lat_p - 1; s++) begin
            for (int l = 0; l < lanes_p; l++) begin
                any_valid_o = any_valid_o | line_q[s][l].valid;
            end
        end
    end

endmodule

// File: rtl/v_lane_seq.sv
// Vector lane sequencer: walks one element-wise operation across the
// banked register file, lane i touching only bank i (element b*lanes_p+i
// in beat b), and retires writes exe_lat_p issue-cycles later.
//   clk_i, reset_n_i    : clock, async active-low reset
//   cmd_v_i, cmd_vl_i   : command valid / requested vector length
//   cmd_ready_o         : high in IDLE; command taken on cmd_v_i & ready
//   stall_i             : freezes issue and write-back, masks r_v/w_en
//   r_addr_o, r_v_o     : per-lane read address / valid
//   w_addr_o, w_en_o    : per-lane write address / enable
//   busy_o              : not IDLE
//   done_o              : one-cycle pulse after the last write retires
//
// state | meaning
// IDLE  | ready for a command; vl=0 commands complete here directly
// ISSUE | presenting one beat of reads per non-stalled cycle
// DRAIN | all reads issued, waiting for the write-back line to empty
module v_lane_seq
    import v_pkg::*;
#(
    parameter  int vlen_p        = v_vlen_lp,
    parameter  int vdw_p         = v_vdw_lp,
    parameter  int lanes_p       = v_lanes_lp,
    parameter  int exe_lat_p     = v_exe_lat_lp,
    localparam int addr_width_lp = $clog2(vlen_p),
    localparam int vl_width_lp   = $clog2(vlen_p + 1),
    localparam int beats_lp      = vlen_p / lanes_p
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   cmd_v_i,
    input  logic [vl_width_lp-1:0]                 cmd_vl_i,
    output logic                                   cmd_ready_o,
    input  logic                                   stall_i,
    output logic [lanes_p-1:0][addr_width_lp-1:0]  r_addr_o,
    output logic [lanes_p-1:0]                     r_v_o,
    output logic [lanes_p-1:0][addr_width_lp-1:0]  w_addr_o,
    output logic [lanes_p-1:0]                     w_en_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    // The lane struct in v_pkg is sized for the package defaults.
    if (vdw_p < 1 || exe_lat_p < 1 || beats_lp * lanes_p != vlen_p ||
        (lanes_p & (lanes_p - 1)) != 0 || addr_width_lp != v_addr_width_lp)
    begin : g_bad_params
        $error("v_lane_seq: unsupported parameter combination");
    end

    typedef lane_addr_t [lanes_p-1:0] beat_t;

    state_e                 state_q, state_d;
    logic [vl_width_lp-1:0] vl_q, vl_d;
    logic [vl_width_lp-1:0] base_q, base_d;   // first element of the next beat
    beat_t                  rd_q, rd_d;
    logic                   done_q, done_d;

    logic [vl_width_lp-1:0] vl_new;
    beat_t                  wb_out;
    logic                   wb_pending;

    function automatic beat_t beat_lanes(logic [vl_width_lp-1:0] base,
                                         logic [vl_width_lp-1:0] vl);
        beat_t b;
        for (int i = 0; i < lanes_p; i++) begin
            b[i].valid = (int'(base) + i) < int'(vl);
            b[i].addr  = addr_t'(int'(base) + i);
        end
        return b;
    endfunction

    assign vl_new = vl_width_lp'(clamp_vl(int'(cmd_vl_i), vlen_p));

    // Beat 0 is loaded on the accepting edge so the first read shows up one
    // cycle after acceptance; each ISSUE cycle then consumes the presented
    // beat and loads the next one.
    always_comb begin
        state_d = state_q;
        vl_d    = vl_q;
        base_d  = base_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_v_i) begin
                    if (vl_new == '0) begin
                        done_d = 1'b1;
                    end else begin
                        vl_d    = vl_new;
                        rd_d    = beat_lanes('0, vl_new);
                        base_d  = vl_width_lp'(lanes_p);
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!stall_i) begin
                    if (base_q < vl_q) begin
                        rd_d   = beat_lanes(base_q, vl_q);
                        base_d = base_q + vl_width_lp'(lanes_p);
                    end else begin
                        for (int i = 0; i < lanes_p; i++) begin
                            rd_d[i].valid = 1'b0;
                        end
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!stall_i && !wb_pending) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            vl_q    <= '0;
            base_q  <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vl_q    <= vl_d;
            base_q  <= base_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    v_wb_delay #(
        .lanes_p   (lanes_p),
        .exe_lat_p (exe_lat_p)
    ) u_wb_delay (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .en_i        (~stall_i),
        .in_i        (rd_q),
        .out_o       (wb_out),
        .any_valid_o (wb_pending)
    );

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = ~cmd_ready_o;
    assign done_o      = done_q;

    always_comb begin
        for (int i = 0; i < lanes_p; i++) begin
            r_addr_o[i] = rd_q[i].addr;
            r_v_o[i]    = rd_q[i].valid & ~stall_i;
            w_addr_o[i] = wb_out[i].addr;
            w_en_o[i]   = wb_out[i].valid & ~stall_i;
        end
    end

endmodule

// File: tb/tb_v_lane_seq.sv
// Self-checking bench for v_lane_seq: expected reads, writes and done
// pulses are computed per command from the stall schedule and queued;
// a monitor compares the DUT against those queues every cycle.
module tb_v_lane_seq;

    localparam int VLEN = 8;
    localparam int VDW  = 32;
    localparam int L    = 4;
    localparam int LAT  = 2;
    localparam int AW   = 3;
    localparam int VW   = 4;
    localparam int MAXC = 4096;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  cmd_v = 1'b0;
    logic [VW-1:0]         cmd_vl = '0;
    logic                  stall = 1'b0;
    logic                  cmd_ready, busy, done;
    logic [L-1:0][AW-1:0]  r_addr, w_addr;
    logic [L-1:0]          r_v, w_en;

    v_lane_seq #(
        .vlen_p    (VLEN),
        .vdw_p     (VDW),
        .lanes_p   (L),
        .exe_lat_p (LAT)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .cmd_v_i     (cmd_v),
        .cmd_vl_i    (cmd_vl),
        .cmd_ready_o (cmd_ready),
        .stall_i     (stall),
        .r_addr_o    (r_addr),
        .r_v_o       (r_v),
        .w_addr_o    (w_addr),
        .w_en_o      (w_en),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   cyc;
        logic [L-1:0]         mask;
        logic [L-1:0][AW-1:0] addr;
    } beat_ev_t;

    beat_ev_t rd_exp[$];
    beat_ev_t wr_exp[$];
    int       done_exp[$];
    bit       stall_sched[MAXC];
    bit       ready_exp[MAXC];

    int cyc = 0;
    bit chk_en = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string what, logic [63:0] act, logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, wanted %0h", what, cyc, act, exp_v);
        end
    endtask

    function automatic int next_free(int c);
        while (c < MAXC - 1 && stall_sched[c]) c++;
        return c;
    endfunction

    // Reference: beat b reads in the b-th non-stalled cycle after acceptance;
    // its write lands on the LAT-th non-stalled cycle after that read; done
    // follows the last write; ready is low from acceptance until done.
    task automatic model_cmd(int a, int vl_raw, output int d);
        int vl, c, cw, k;
        beat_ev_t ev;
        vl = (vl_raw > VLEN) ? VLEN : vl_raw;
        if (vl == 0) begin
            d = a + 1;
            done_exp.push_back(d);
            return;
        end
        c  = a + 1;
        cw = a;
        for (int e0 = 0; e0 < vl; e0 += L) begin
            c      = next_free(c);
            ev.cyc = c;
            ev.mask = '0;
            ev.addr = '0;
            for (int i = 0; i < L; i++) begin
                ev.addr[i] = AW'(e0 + i);
                ev.mask[i] = (e0 + i) < vl;
            end
            rd_exp.push_back(ev);
            cw = c;
            k  = 0;
            while (k < LAT && cw < MAXC - 1) begin
                cw++;
                if (!stall_sched[cw]) k++;
            end
            ev.cyc = cw;
            wr_exp.push_back(ev);
            c = c + 1;
        end
        d = cw + 1;
        done_exp.push_back(d);
        for (int j = a + 1; j < d && j < MAXC; j++) ready_exp[j] = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_ev_t             ev;
        logic [L-1:0]         m;
        logic [L-1:0][AW-1:0] a_act, a_exp;
        bit                   dn;
        if (chk_en) begin
            m = '0;
            a_exp = '0;
            if (rd_exp.size() > 0 && rd_exp[0].cyc == cyc) begin
                ev = rd_exp.pop_front();
                m = ev.mask;
                a_exp = ev.addr;
            end
            check("r_v_o", r_v, m);
            if (m != '0) begin
                a_act = r_addr;
                for (int i = 0; i < L; i++) if (!m[i]) begin a_act[i] = '0; a_exp[i] = '0; end
                check("r_addr_o", a_act, a_exp);
            end

            m = '0;
            a_exp = '0;
            if (wr_exp.size() > 0 && wr_exp[0].cyc == cyc) begin
                ev = wr_exp.pop_front();
                m = ev.mask;
                a_exp = ev.addr;
            end
            check("w_en_o", w_en, m);
            if (m != '0) begin
                a_act = w_addr;
                for (int i = 0; i < L; i++) if (!m[i]) begin a_act[i] = '0; a_exp[i] = '0; end
                check("w_addr_o", a_act, a_exp);
            end
            for (int i = 0; i < L; i++) begin
                if (w_en[i]) check("w_bank", 64'(w_addr[i][1:0]), 64'(i));
            end

            dn = (done_exp.size() > 0 && done_exp[0] == cyc);
            if (dn) void'(done_exp.pop_front());
            check("done_o", done, dn);
            check("cmd_ready_o", cmd_ready, ready_exp[cyc]);
            check("busy_o", busy, !ready_exp[cyc]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int vl);
        cmd_v  = v;
        cmd_vl = VW'(vl);
        stall  = stall_sched[cyc];
    endtask

    // mode 0: no stalls around the command, 1: random stalls,
    // 2: stall only in cycles 2 and 3 after acceptance
    task automatic issue(int vl, int mode, int gap);
        int a, d;
        repeat (gap) begin
            drive(1'b0, 0);
            step();
        end
        a = cyc;
        if (mode != 1) for (int j = a; j < a + 40 && j < MAXC; j++) stall_sched[j] = 1'b0;
        if (mode == 2) begin
            stall_sched[a + 2] = 1'b1;
            stall_sched[a + 3] = 1'b1;
        end
        model_cmd(a, vl, d);
        drive(1'b1, vl);
        step();
        while (cyc < d) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < MAXC; j++) begin
            stall_sched[j] = ($urandom_range(0, 3) == 0);
            ready_exp[j]   = 1'b1;
        end

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_r_v", r_v, '0);
        check("rst_w_en", w_en, '0);
        check("rst_r_addr", r_addr, '0);
        check("rst_w_addr", w_addr, '0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        reset_n = 1'b1;
        step();
        chk_en = 1'b1;

        issue(6, 0, 1);
        issue(0, 0, 0);
        issue(8, 2, 2);
        issue(15, 0, 0);
        issue(8, 0, 0);
        for (int n = 0; n < 50; n++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)));
        end

        drive(1'b0, 0);
        stall = 1'b0;
        step();
        step();
        chk_en = 1'b0;
        cmd_v = 1'b1;
        cmd_vl = 4'd8;
        stall = 1'b0;
        step();
        cmd_v = 1'b0;
        step();
        step();
        step();
        @(negedge clk);
        check("rst_first_write", w_en, 4'hF);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_r_v", r_v, '0);
        check("midrst_w_en", w_en, '0);
        check("midrst_r_addr", r_addr, '0);
        check("midrst_w_addr", w_addr, '0);
        check("midrst_done", done, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("inrst_w_en", w_en, '0);
            check("inrst_r_v", r_v, '0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk_en = 1'b1;
        issue(4, 0, 0);

        drive(1'b0, 0);
        repeat (LAT + 3) step();
        chk_en = 1'b0;
        check("rd_left", rd_exp.size(), 0);
        check("wr_left", wr_exp.size(), 0);
        check("done_left", done_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
